// File: rtl/feature_frame_tx.sv
// Frames per-channel epoch features into a checksummed byte stream on a valid/ready link.
// A shadow buffer lets capture of the next epoch overlap transmission of the current one.
module feature_frame_tx #(
  parameter int N_CH         = 4,
  parameter int EPOCH_LENGTH = 256,
  localparam int FEAT_W      = $clog2(EPOCH_LENGTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [N_CH*FEAT_W-1:0]   feat_in,
  input  logic [N_CH-1:0]          feat_valid,
  output logic [7:0]               m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic                     busy,
  output logic                     overrun
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [4:0] LAST_CNT  = 5'(2 * N_CH - 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_STAT, S_FEAT, S_CSUM} state_t;

  state_t            r_state, w_state_nxt;
  logic [N_CH-1:0]   r_v_q, r_flag;
  logic [N_CH-1:0]   w_event, w_overwrite;
  logic [FEAT_W-1:0] r_cap    [N_CH];
  logic [FEAT_W-1:0] r_shadow [N_CH];
  logic              r_ovf_pend, r_ovf_sh, r_overrun;
  logic [6:0]        r_idx, w_idx_nxt;
  logic [7:0]        r_csum, w_csum_nxt;
  logic [4:0]        r_byte_cnt, w_cnt_nxt;
  logic [7:0]        r_m_data, w_data_nxt;
  logic              r_m_valid, w_valid_nxt;
  logic              r_m_last, w_last_nxt;
  logic              w_launch, w_hs;
  logic [4:0]        w_sel_cnt;
  logic [15:0]       w_sel_feat;
  logic [7:0]        w_feat_byte;

  assign w_hs     = r_m_valid & m_ready;
  assign w_launch = (r_state == S_IDLE) & (&r_flag);
  assign w_event  = feat_valid & ~r_v_q & {N_CH{en}};
  // A capture in the launch cycle starts the next frame; the old value is already shadowed.
  assign w_overwrite = w_event & r_flag & {N_CH{~w_launch}};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v_q      <= '0;
      r_flag     <= '0;
      r_ovf_pend <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_v_q <= en ? feat_valid : '0;
      if (!en) begin
        r_flag     <= '0;
        r_ovf_pend <= 1'b0;
      end else begin
        r_flag <= (w_launch ? '0 : r_flag) | w_event;
        if (|w_overwrite) r_ovf_pend <= 1'b1;
        else if (w_launch) r_ovf_pend <= 1'b0;
      end
      if (|w_overwrite) r_overrun <= 1'b1;
    end
  end

  // NOTE: capture and shadow storage carry no reset; the flags guarantee they are written before use.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (w_event[i]) r_cap[i] <= feat_in[i*FEAT_W +: FEAT_W];
      if (w_launch)   r_shadow[i] <= r_cap[i];
    end
  end

  // Byte to present after the current handshake: STAT leads into feature byte 0.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    w_sel_cnt  = (r_state == S_STAT) ? 5'd0 : r_byte_cnt + 5'd1;
    w_sel_feat = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_sel_cnt[4:1] == 4'(i)) w_sel_feat = 16'(r_shadow[i]);
    end
    w_feat_byte = w_sel_cnt[0] ? w_sel_feat[7:0] : w_sel_feat[15:8];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_m_data;
    w_valid_nxt = r_m_valid;
    w_last_nxt  = r_m_last;
    w_cnt_nxt   = r_byte_cnt;
    w_csum_nxt  = r_csum;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (w_launch) begin
          w_state_nxt = S_HDR;
          w_data_nxt  = SYNC_BYTE;
          w_valid_nxt = 1'b1;
          w_last_nxt  = 1'b0;
          w_csum_nxt  = SYNC_BYTE;
          w_cnt_nxt   = '0;
        end
      end
      S_HDR: begin
        if (w_hs) begin
          w_state_nxt = S_STAT;
          w_data_nxt  = {r_ovf_sh, r_idx};
          w_csum_nxt  = r_csum ^ {r_ovf_sh, r_idx};
        end
      end
      S_STAT: begin
        if (w_hs) begin
          w_state_nxt = S_FEAT;
          w_data_nxt  = w_feat_byte;
          w_csum_nxt  = r_csum ^ w_feat_byte;
          w_cnt_nxt   = '0;
        end
      end
      S_FEAT: begin
        if (w_hs) begin
          if (r_byte_cnt == LAST_CNT) begin
            w_state_nxt = S_CSUM;
            w_data_nxt  = r_csum;
            w_last_nxt  = 1'b1;
          end else begin
            w_data_nxt = w_feat_byte;
            w_csum_nxt = r_csum ^ w_feat_byte;
            w_cnt_nxt  = r_byte_cnt + 5'd1;
          end
        end
      end
      S_CSUM: begin
        if (w_hs) begin
          w_state_nxt = S_IDLE;
          w_data_nxt  = 8'h00;
          w_valid_nxt = 1'b0;
          w_last_nxt  = 1'b0;
          w_idx_nxt   = r_idx + 7'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_m_data   <= 8'h00;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_byte_cnt <= '0;
      r_csum     <= 8'h00;
      r_idx      <= 7'd0;
      r_ovf_sh   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_m_data   <= w_data_nxt;
      r_m_valid  <= w_valid_nxt;
      r_m_last   <= w_last_nxt;
      r_byte_cnt <= w_cnt_nxt;
      r_csum     <= w_csum_nxt;
      r_idx      <= w_idx_nxt;
      if (w_launch) r_ovf_sh <= r_ovf_pend;
    end
  end

  assign m_data  = r_m_data;
  assign m_valid = r_m_valid;
  assign m_last  = r_m_last;
  assign busy    = (r_state != S_IDLE);
  assign overrun = r_overrun;

endmodule
